// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue block: FSM encoding, unit indices and
// the quiet-NaN pattern returned on a unit timeout.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0]  UNIT_FADD = 2'd0;
    localparam logic [1:0]  UNIT_FSUB = 2'd1;
    localparam logic [1:0]  UNIT_FMUL = 2'd2;
    localparam logic [1:0]  UNIT_FDIV = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/temp_reg.sv
// Register primitive: synchronous active-low reset to RST_VAL, load on en.
module temp_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fpu_issue.sv
// Single-outstanding issue stage: captures one FP request, orders it to the
// selected unit, waits for its result (with timeout) and holds the response.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int N_UNITS        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_unit,
    input  logic [31:0]           req_rs1,
    input  logic [31:0]           req_rs2,
    input  logic [4:0]            req_tag,
    output logic [N_UNITS-1:0]    unit_order,
    input  logic [N_UNITS-1:0]    unit_accepted,
    input  logic [N_UNITS-1:0]    unit_done,
    output logic [31:0]           unit_rs1,
    output logic [31:0]           unit_rs2,
    input  logic [32*N_UNITS-1:0] unit_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [4:0]            resp_tag,
    output logic                  resp_err,
    output logic                  busy
);

    logic [1:0]  state_raw;
    state_e      state_q;
    state_e      state_d;
    logic [1:0]  unit_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [4:0]  tag_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        err_q;
    logic        err_d;
    logic        capture;
    logic        load_resp;

    logic [N_UNITS-1:0] acc_hit;
    logic [N_UNITS-1:0] done_hit;
    logic               acc_sel;
    logic               done_sel;
    logic [31:0]        rd_sel;

    assign state_q = state_e'(state_raw);

    // Only the addressed unit's handshakes count; every other bit is masked off.
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
        assign acc_hit[gi]    = unit_accepted[gi] && (unit_q == 2'(gi));
        assign done_hit[gi]   = unit_done[gi] && (unit_q == 2'(gi));
        assign unit_order[gi] = (state_q == ST_ISSUE) && (unit_q == 2'(gi));
    end

    assign acc_sel  = |acc_hit;
    assign done_sel = |done_hit;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (unit_q == 2'(i)) begin
                rd_sel = unit_rd[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        capture   = 1'b0;
        load_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (acc_sel) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A done arriving in the final allowed cycle still beats the timeout.
                if (done_sel) begin
                    data_d    = rd_sel;
                    err_d     = 1'b0;
                    load_resp = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    data_d    = QNAN;
                    err_d     = 1'b1;
                    load_resp = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    temp_reg #(.W(2), .RST_VAL(ST_IDLE)) u_state_reg (
        .clk(clk), .rstn(rstn), .en(1'b1), .d(state_d), .q(state_raw)
    );
    temp_reg #(.W(2)) u_unit_reg (
        .clk(clk), .rstn(rstn), .en(capture), .d(req_unit), .q(unit_q)
    );
    temp_reg #(.W(32)) u_rs1_reg (
        .clk(clk), .rstn(rstn), .en(capture), .d(req_rs1), .q(rs1_q)
    );
    temp_reg #(.W(32)) u_rs2_reg (
        .clk(clk), .rstn(rstn), .en(capture), .d(req_rs2), .q(rs2_q)
    );
    temp_reg #(.W(5)) u_tag_reg (
        .clk(clk), .rstn(rstn), .en(capture), .d(req_tag), .q(tag_q)
    );
    temp_reg #(.W(8)) u_cnt_reg (
        .clk(clk), .rstn(rstn), .en(1'b1), .d(cnt_d), .q(cnt_q)
    );
    temp_reg #(.W(32)) u_data_reg (
        .clk(clk), .rstn(rstn), .en(load_resp), .d(data_d), .q(data_q)
    );
    temp_reg #(.W(1)) u_err_reg (
        .clk(clk), .rstn(rstn), .en(load_resp), .d(err_d), .q(err_q)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign unit_rs1   = rs1_q;
    assign unit_rs2   = rs2_q;
    assign resp_data  = data_q;
    assign resp_tag   = tag_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Randomised bench for fpu_issue: stub units driven per cycle, expected
// response timing and contents derived from the operation's parameters.
module tb_fpu_issue;

    localparam int          TMO  = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_unit;
    logic [31:0]  req_rs1;
    logic [31:0]  req_rs2;
    logic [4:0]   req_tag;
    logic [3:0]   unit_order;
    logic [3:0]   unit_accepted;
    logic [3:0]   unit_done;
    logic [31:0]  unit_rs1;
    logic [31:0]  unit_rs2;
    logic [127:0] unit_rd;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data;
    logic [4:0]   resp_tag;
    logic         resp_err;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    fpu_issue #(.N_UNITS(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .unit_order(unit_order), .unit_accepted(unit_accepted), .unit_done(unit_done),
        .unit_rs1(unit_rs1), .unit_rs2(unit_rs2), .unit_rd(unit_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selected unit sees only the intended handshake; the others see random noise.
    task automatic noise(input logic [1:0] u, input bit acc, input bit dn);
        logic [3:0] m;
        m = 4'b0001 << u;
        unit_accepted = (4'($urandom) & ~m) | (acc ? m : 4'b0000);
        unit_done     = (4'($urandom) & ~m) | (dn ? m : 4'b0000);
    endtask

    task automatic check_reset_outs(input string who);
        check({who, "_order"}, 32'(unit_order), 32'd0);
        check({who, "_rvalid"}, 32'(resp_valid), 32'd0);
        check({who, "_busy"}, 32'(busy), 32'd0);
        check({who, "_rdy"}, 32'(req_ready), 32'd1);
        check({who, "_data"}, resp_data, 32'd0);
        check({who, "_tag"}, 32'(resp_tag), 32'd0);
        check({who, "_err"}, 32'(resp_err), 32'd0);
    endtask

    // One operation. done_w: WAIT cycle (1-based) in which the unit raises done;
    // values above TMO mean never. rst_w: WAIT cycle in which rstn is pulsed (0 = none).
    task automatic do_op(input logic [1:0] u, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] tag, input logic [31:0] res, input int acc_dly,
                         input int done_w, input int bp, input int rst_w);
        logic [31:0] exp_data;
        logic        exp_err;
        logic [3:0]  m;
        m        = 4'b0001 << u;
        exp_err  = (done_w > TMO);
        exp_data = exp_err ? QNAN : res;
        unit_rd  = {$urandom, $urandom, $urandom, $urandom};
        unit_rd[32*int'(u) +: 32] = res;

        check("idle_rdy", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_order", 32'(unit_order), 32'd0);
        req_valid  = 1'b1;
        req_unit   = u;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_tag    = tag;
        resp_ready = 1'($urandom);
        noise(u, 1'b0, 1'b0);
        step();

        for (int i = 0; i <= acc_dly; i++) begin
            check("issue_order", 32'(unit_order), 32'(m));
            check("issue_rs1", unit_rs1, rs1);
            check("issue_rs2", unit_rs2, rs2);
            check("issue_rdy", 32'(req_ready), 32'd0);
            check("issue_rvalid", 32'(resp_valid), 32'd0);
            req_valid = 1'($urandom);
            req_unit  = 2'($urandom);
            req_rs1   = $urandom;
            req_rs2   = $urandom;
            req_tag   = 5'($urandom);
            noise(u, i == acc_dly, 1'b0);
            step();
        end

        for (int w = 1; w <= TMO; w++) begin
            check("wait_order", 32'(unit_order), 32'd0);
            check("wait_rvalid", 32'(resp_valid), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_rs1", unit_rs1, rs1);
            req_rs1 = $urandom;
            if (w == rst_w) begin
                rstn = 1'b0;
                noise(u, 1'b0, 1'b0);
                step();
                check_reset_outs("midrst");
                req_valid = 1'b0;
                rstn      = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    noise(u, 1'b0, 1'b1);
                    step();
                    check("postrst_rvalid", 32'(resp_valid), 32'd0);
                    check("postrst_busy", 32'(busy), 32'd0);
                end
                unit_done = 4'b0000;
                return;
            end
            noise(u, 1'b0, w == done_w);
            step();
            if (w == done_w) break;
        end

        for (int i = 0; i <= bp; i++) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_data", resp_data, exp_data);
            check("resp_tag", 32'(resp_tag), 32'(tag));
            check("resp_err", 32'(resp_err), 32'(exp_err));
            check("resp_rdy", 32'(req_ready), 32'd0);
            check("resp_order", 32'(unit_order), 32'd0);
            check("resp_rs1", unit_rs1, rs1);
            req_valid  = 1'($urandom);
            req_rs1    = $urandom;
            unit_rd    = {$urandom, $urandom, $urandom, $urandom};
            resp_ready = (i == bp);
            noise(u, 1'b0, 1'b0);
            step();
        end

        check("done_rvalid", 32'(resp_valid), 32'd0);
        check("done_rdy", 32'(req_ready), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        req_valid     = 1'b0;
        req_unit      = '0;
        req_rs1       = '0;
        req_rs2       = '0;
        req_tag       = '0;
        unit_accepted = '0;
        unit_done     = '0;
        unit_rd       = '0;
        resp_ready    = 1'b0;
        step();
        step();
        check_reset_outs("reset");
        rstn = 1'b1;

        // fmul 2.0 * 3.0, unit accepts with the order, response on cycle 5
        do_op(2'd2, 32'h4000_0000, 32'h4040_0000, 5'd7, 32'h40C0_0000, 0, 3, 0, 0);
        // backpressure for three cycles
        do_op(2'd2, 32'h3F80_0000, 32'h4000_0000, 5'd12, 32'h4000_0000, 0, 3, 3, 0);
        // stub never completes -> timeout, then a normal op
        do_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'h0BAD_F00D, 1, 1000, 1, 0);
        do_op(2'd3, 32'h4100_0000, 32'h4000_0000, 5'd30, 32'h4080_0000, 0, 4, 0, 0);
        // done in the last allowed WAIT cycle still wins
        do_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd31, 32'h4000_0000, 2, TMO, 0, 0);
        // reset during WAIT abandons the op
        do_op(2'd2, 32'h4000_0000, 32'h4040_0000, 5'd9, 32'h40C0_0000, 1, 5, 0, 2);

        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom), $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(1, 6)),
                  int'($urandom_range(0, 3)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter N_UNITS, default 4: number of attached FPU units; unit index is 2 bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles in WAIT before an error response.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  request present; req_ready  out  1  block can take a request.
REQ-006 req_unit  in  2  target unit index (0 fadd, 1 fsub, 2 fmul, 3 fdiv).
REQ-007 req_rs1, req_rs2  in  32 each  IEEE-754 single operands; req_tag  in  5  destination register tag.
REQ-008 unit_order  out  N_UNITS  one-hot order to units; unit_accepted, unit_done  in  N_UNITS each.
REQ-009 unit_rs1, unit_rs2  out  32 each  shared operand bus to all units.
REQ-010 unit_rd  in  32*N_UNITS  packed unit results; unit i at bits [32i+31:32i].
REQ-011 resp_valid  out  1; resp_ready  in  1; resp_data  out  32; resp_tag  out  5; resp_err  out  1  timeout flag.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, ISSUE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-014 IDLE: req_valid & req_ready captures req_unit, req_rs1, req_rs2, req_tag into registers; next state ISSUE.
REQ-015 unit_rs1/unit_rs2 driven from captured registers, stable from ISSUE entry until return to IDLE; req_* changes after capture have no effect.
REQ-016 ISSUE: unit_order bit[unit] = 1, all other bits 0; stays asserted until unit_accepted[unit] is sampled high.
REQ-017 ISSUE with unit_accepted[unit] = 1: next state WAIT; unit_order = 0 in every state except ISSUE, so order drops the following cycle and the unit is never re-triggered.
REQ-018 WAIT: unit_done[unit] = 1 captures unit_rd[unit] into resp_data, resp_err = 0; next state RESP.
REQ-019 unit_accepted/unit_done on non-selected units ignored in every state.
REQ-020 WAIT cycle counter (8 bits) cleared on WAIT entry, increments each WAIT cycle; reaching TIMEOUT_CYCLES without done -> RESP with resp_data = 0x7FC00000, resp_err = 1.
REQ-021 Done on the same cycle the counter reaches TIMEOUT_CYCLES: done wins, resp_err = 0.
REQ-022 RESP: resp_valid = 1; resp_data, resp_tag, resp_err held stable until resp_ready = 1, then next state IDLE.
REQ-023 No request accepted in RESP (no overlap); throughput one op per unit latency + 3 cycles minimum.
REQ-024 Latency with a fmul-type unit (accepted same cycle as order, done 2 cycles later): request handshake at cycle 0 -> resp_valid at cycle 5.
REQ-025 resp_valid, unit_order and busy are registered-state decodes only; no combinational path from req_valid to unit_order.

Reset
REQ-026 rstn low at a clock edge: state IDLE, unit_order = 0, resp_valid = 0, resp_err = 0, resp_data = 0, resp_tag = 0, counter = 0, busy = 0, req_ready = 1 in the first cycle after reset.
REQ-027 Reset mid-operation (any state) abandons the operation with no response; units share rstn and are reset together.

Structure
REQ-028 Shared package fpu_pkg holds FSM state encoding, unit index constants UNIT_FADD/FSUB/FMUL/FDIV, and QNAN = 0x7FC00000.
REQ-029 All registers instantiated through the existing temp_reg register primitive; no other sub-module.

Verification
REQ-030 fmul on unit 2: rs1 0x40000000, rs2 0x40400000, tag 7, resp_ready = 1 -> resp_valid at cycle 5, resp_data 0x40C00000, resp_tag 7, resp_err 0.
REQ-031 Backpressure: resp_ready low 3 cycles in RESP -> resp_valid and resp_data stable 4 cycles, req_ready 0 throughout, IDLE after handshake.
REQ-032 Stub unit never raises done -> after 255 WAIT cycles resp_data 0x7FC00000, resp_err 1; next request completes normally.
REQ-033 Spurious unit_done[0] and unit_accepted[1] while an op on unit 2 is in WAIT -> ignored; result from unit 2 only.
REQ-034 rstn low during WAIT -> next cycle unit_order 0, resp_valid 0, busy 0, req_ready 1; no response emitted.
REQ-035 req_rs1 toggled every cycle after capture -> unit_rs1 constant until IDLE; unit_order one cycle wide for a same-cycle-accepting unit.
